// File: rtl/mem_bus_ctrl_if.sv
// Signal bundle joining the CPU fetch/data ports and the unified RAM to the memory bus controller.
interface mem_bus_ctrl_if;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_ready;
   logic [31:0] if_rdata;
   logic        d_req;
   logic        d_we;
   logic [1:0]  d_size;
   logic        d_unsigned;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic        d_ready;
   logic [31:0] d_rdata;
   logic        d_misalign;
   logic [31:0] ram_addr;
   logic        ram_wr_en;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   modport slave (
      input  if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, ram_rdata,
      output if_ready, if_rdata, d_ready, d_rdata, d_misalign, ram_addr, ram_wr_en, ram_wdata
   );

   modport master (
      output if_req, if_addr, d_req, d_we, d_size, d_unsigned, d_addr, d_wdata, ram_rdata,
      input  if_ready, if_rdata, d_ready, d_rdata, d_misalign, ram_addr, ram_wr_en, ram_wdata
   );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Single-port RAM controller: arbitrates fetch vs data, does read-modify-write for sub-word
// stores, extends sub-word loads and rejects misaligned data accesses.
module mem_bus_ctrl #(
   parameter bit FAIR_ARB = 1'b1
) (
   input logic           clk,
   input logic           rst_n,
   input logic           clk_en,
   mem_bus_ctrl_if.slave bus
);

   typedef enum logic [2:0] {IDLE, READ, RMW_RD, WRITE, RESP} state_t;

   state_t      state, next_state;
   logic [1:0]  addr_lo, size;
   logic        is_unsigned, src_data, last_grant;
   logic [15:0] wdata;
   logic [31:0] merge_word, ram_addr_q, if_rdata_q, d_rdata_q;
   logic        if_ready_q, d_ready_q, d_misalign_q;
   logic        grant_data, grant_fetch, misaligned;
   logic [31:0] sel_addr;

   function automatic logic [31:0] extend_load(input logic [31:0] word, input logic [1:0] lo,
                                               input logic [1:0] sz, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      logic [31:0] r;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (sz)
         2'b00:   r = uns ? {24'h0, b} : {{24{b[7]}}, b};
         2'b01:   r = uns ? {16'h0, h} : {{16{h[15]}}, h};
         default: r = word;
      endcase
      return r;
   endfunction

   function automatic logic [31:0] merge_store(input logic [31:0] word, input logic [15:0] data,
                                               input logic [1:0] lo, input logic [1:0] sz);
      logic [31:0] r;
      r = word;
      if (sz == 2'b00) r[{lo, 3'b000} +: 8] = data[7:0];
      else             r[{lo[1], 4'b0000} +: 16] = data;
      return r;
   endfunction

   // With FAIR_ARB a data grant hands the next tie to fetch; otherwise data always wins.
   always_comb begin
      grant_data  = bus.d_req && !(bus.if_req && FAIR_ARB && last_grant);
      grant_fetch = bus.if_req && !grant_data;
      sel_addr    = grant_data ? bus.d_addr : bus.if_addr;
      case (bus.d_size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = bus.d_addr[0];
         2'b10:   misaligned = |bus.d_addr[1:0];
         default: misaligned = 1'b1;
      endcase
   end

   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (grant_data) begin
               if (misaligned)              next_state = RESP;
               else if (!bus.d_we)          next_state = READ;
               else if (bus.d_size == 2'b10) next_state = WRITE;
               else                         next_state = RMW_RD;
            end else if (grant_fetch) begin
               next_state = READ;
            end
         end
         READ:    next_state = RESP;
         RMW_RD:  next_state = WRITE;
         WRITE:   next_state = RESP;
         RESP:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      state <= IDLE;
      else if (clk_en) state <= next_state;
   end

   // Ready outputs are loaded on the edge entering RESP so they are high exactly while in RESP.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_lo      <= 2'b00;
         size         <= 2'b00;
         is_unsigned  <= 1'b0;
         src_data     <= 1'b0;
         last_grant   <= 1'b0;
         wdata        <= 16'h0;
         merge_word   <= 32'h0;
         ram_addr_q   <= 32'h0;
         if_rdata_q   <= 32'h0;
         d_rdata_q    <= 32'h0;
         if_ready_q   <= 1'b0;
         d_ready_q    <= 1'b0;
         d_misalign_q <= 1'b0;
      end else if (clk_en) begin
         case (state)
            IDLE: begin
               if (grant_data || grant_fetch) begin
                  last_grant  <= grant_data;
                  src_data    <= grant_data;
                  addr_lo     <= sel_addr[1:0];
                  size        <= grant_data ? bus.d_size : 2'b10;
                  is_unsigned <= bus.d_unsigned;
                  wdata       <= bus.d_wdata[15:0];
                  if (next_state == RESP) begin
                     d_ready_q    <= 1'b1;
                     d_misalign_q <= 1'b1;
                     d_rdata_q    <= 32'h0;
                  end else begin
                     ram_addr_q <= {sel_addr[31:2], 2'b00};
                  end
                  if (next_state == WRITE) merge_word <= bus.d_wdata;
               end
            end
            READ: begin
               if (src_data) begin
                  d_ready_q <= 1'b1;
                  d_rdata_q <= extend_load(bus.ram_rdata, addr_lo, size, is_unsigned);
               end else begin
                  if_ready_q <= 1'b1;
                  if_rdata_q <= bus.ram_rdata;
               end
            end
            RMW_RD: merge_word <= merge_store(bus.ram_rdata, wdata, addr_lo, size);
            WRITE: begin
               d_ready_q <= 1'b1;
               d_rdata_q <= 32'h0;
            end
            RESP: begin
               if_ready_q   <= 1'b0;
               d_ready_q    <= 1'b0;
               d_misalign_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

   assign bus.if_ready   = if_ready_q;
   assign bus.if_rdata   = if_rdata_q;
   assign bus.d_ready    = d_ready_q;
   assign bus.d_rdata    = d_rdata_q;
   assign bus.d_misalign = d_misalign_q;
   assign bus.ram_addr   = ram_addr_q;
   assign bus.ram_wdata  = merge_word;
   assign bus.ram_wr_en  = (state == WRITE) && clk_en;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Directed bench for mem_bus_ctrl: loads, stores, misalignment, arbitration, reset and clk_en stalls.
module tb_mem_bus_ctrl;

   logic clk = 1'b0;
   logic rst_n;
   logic clk_en;
   int   checks = 0;
   int   fails = 0;
   logic [31:0] mem [0:1023];

   mem_bus_ctrl_if bus ();
   mem_bus_ctrl_if bus0 ();

   mem_bus_ctrl #(.FAIR_ARB(1'b1)) dut  (.clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus));
   mem_bus_ctrl #(.FAIR_ARB(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .clk_en(clk_en), .bus(bus0));

   always #5 clk = ~clk;

   assign bus.ram_rdata  = mem[bus.ram_addr[11:2]];
   assign bus0.ram_rdata = 32'h0;

   always @(posedge clk) begin
      if (bus.ram_wr_en) mem[bus.ram_addr[11:2]] = bus.ram_wdata;
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         fails++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   // Issues one data request and waits (bounded) for its completion pulse.
   task automatic applyStimulus(input logic we, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                output int lat, output logic [31:0] rdata, output logic mis,
                                output int wr_cnt, output logic [31:0] wr_word);
      bus.d_req = 1'b1; bus.d_we = we; bus.d_size = sz; bus.d_unsigned = uns;
      bus.d_addr = addr; bus.d_wdata = wd;
      lat = 0; wr_cnt = 0; wr_word = 32'h0;
      do begin
         tick();
         lat++;
         if (bus.ram_wr_en) begin
            wr_cnt++;
            wr_word = bus.ram_wdata;
         end
      end while (!bus.d_ready && lat < 20);
      if (!bus.d_ready) checkOutput("d_ready_timeout", {31'h0, bus.d_ready}, 32'h1);
      rdata = bus.d_rdata;
      mis = bus.d_misalign;
      bus.d_req = 1'b0;
      tick();
   endtask

   task automatic runLoad(input string tag, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] exp);
      int lat, wc;
      logic [31:0] rd, ww;
      logic mis;
      applyStimulus(1'b0, sz, uns, addr, 32'h0, lat, rd, mis, wc, ww);
      checkOutput({tag, "_data"}, rd, exp);
      checkOutput({tag, "_lat"}, lat, 2);
      checkOutput({tag, "_wr"}, wc, 0);
   endtask

   initial begin
      int lat, wc, hi;
      int n1, n0;
      logic [31:0] rd, ww;
      logic mis, seen;
      logic [3:0] seq1, seq0;

      for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
      mem[10'h040] = 32'hDEADBEEF;
      mem[10'h041] = 32'h0BADC0DE;
      mem[10'h080] = 32'h80FF0102;
      mem[10'h0C0] = 32'h11223344;

      rst_n = 1'b0; clk_en = 1'b1;
      bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.d_req = 1'b0; bus.d_we = 1'b0;
      bus.d_size = 2'b00; bus.d_unsigned = 1'b0; bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
      bus0.if_req = 1'b0; bus0.if_addr = 32'h0; bus0.d_req = 1'b0; bus0.d_we = 1'b0;
      bus0.d_size = 2'b10; bus0.d_unsigned = 1'b0; bus0.d_addr = 32'h0; bus0.d_wdata = 32'h0;
      $display("[TB] start");

      repeat (2) @(negedge clk);
      checkOutput("rst_d_ready", {31'h0, bus.d_ready}, 32'h0);
      checkOutput("rst_if_ready", {31'h0, bus.if_ready}, 32'h0);
      checkOutput("rst_misalign", {31'h0, bus.d_misalign}, 32'h0);
      checkOutput("rst_ram_addr", bus.ram_addr, 32'h0);
      checkOutput("rst_ram_wdata", bus.ram_wdata, 32'h0);
      checkOutput("rst_wr_en", {31'h0, bus.ram_wr_en}, 32'h0);
      checkOutput("rst_d_rdata", bus.d_rdata, 32'h0);
      checkOutput("rst_if_rdata", bus.if_rdata, 32'h0);
      rst_n = 1'b1;
      tick();

      runLoad("lw_100", 2'b10, 1'b0, 32'h100, 32'hDEADBEEF);
      runLoad("lb_203", 2'b00, 1'b0, 32'h203, 32'hFFFFFF80);
      runLoad("lbu_203", 2'b00, 1'b1, 32'h203, 32'h00000080);
      runLoad("lh_202", 2'b01, 1'b0, 32'h202, 32'hFFFF80FF);
      runLoad("lhu_200", 2'b01, 1'b1, 32'h200, 32'h00000102);

      applyStimulus(1'b1, 2'b00, 1'b0, 32'h301, 32'h000000AB, lat, rd, mis, wc, ww);
      checkOutput("sb_lat", lat, 3);
      checkOutput("sb_wr_cnt", wc, 1);
      checkOutput("sb_wr_word", ww, 32'h1122AB44);
      checkOutput("sb_ram", mem[10'h0C0], 32'h1122AB44);

      applyStimulus(1'b1, 2'b01, 1'b0, 32'h302, 32'h00005566, lat, rd, mis, wc, ww);
      checkOutput("sh_lat", lat, 3);
      checkOutput("sh_ram", mem[10'h0C0], 32'h5566AB44);

      applyStimulus(1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFEF00D, lat, rd, mis, wc, ww);
      checkOutput("sw_lat", lat, 2);
      checkOutput("sw_wr_cnt", wc, 1);
      checkOutput("sw_ram", mem[10'h100], 32'hCAFEF00D);

      applyStimulus(1'b0, 2'b10, 1'b0, 32'h102, 32'h0, lat, rd, mis, wc, ww);
      checkOutput("mis_lw_lat", lat, 1);
      checkOutput("mis_lw_flag", {31'h0, mis}, 32'h1);
      checkOutput("mis_lw_data", rd, 32'h0);
      applyStimulus(1'b1, 2'b01, 1'b0, 32'h105, 32'h0000FFFF, lat, rd, mis, wc, ww);
      checkOutput("mis_sh_lat", lat, 1);
      checkOutput("mis_sh_flag", {31'h0, mis}, 32'h1);
      checkOutput("mis_sh_wr", wc, 0);
      checkOutput("mis_sh_ram", mem[10'h041], 32'h0BADC0DE);
      applyStimulus(1'b0, 2'b11, 1'b0, 32'h100, 32'h0, lat, rd, mis, wc, ww);
      checkOutput("mis_size11_flag", {31'h0, mis}, 32'h1);
      checkOutput("mis_lw_ok_flag_clear", {31'h0, bus.d_misalign}, 32'h0);

      // Reset asserted while the sub-word store is in its read phase.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b00; bus.d_addr = 32'h300;
      bus.d_wdata = 32'h000000EE;
      tick();
      rst_n = 1'b0;
      #1;
      checkOutput("abort_ram_addr", bus.ram_addr, 32'h0);
      checkOutput("abort_wr_en", {31'h0, bus.ram_wr_en}, 32'h0);
      checkOutput("abort_ram_wdata", bus.ram_wdata, 32'h0);
      bus.d_req = 1'b0;
      seen = 1'b0;
      repeat (3) begin tick(); seen |= bus.d_ready | bus.d_misalign; end
      rst_n = 1'b1;
      repeat (3) begin tick(); seen |= bus.d_ready; end
      checkOutput("abort_no_ready", {31'h0, seen}, 32'h0);
      checkOutput("abort_ram", mem[10'h0C0], 32'h5566AB44);

      // Both requesters held high continuously on both arbitration variants.
      bus.if_req = 1'b1; bus.if_addr = 32'h200;
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h100;
      bus0.if_req = 1'b1; bus0.d_req = 1'b1;
      n1 = 0; n0 = 0; seq1 = 4'h0; seq0 = 4'h0;
      for (int c = 0; c < 40 && (n1 < 4 || n0 < 4); c++) begin
         tick();
         if (n1 < 4 && bus.d_ready) begin
            seq1 = {seq1[2:0], 1'b1}; n1++;
            checkOutput("arb_d_rdata", bus.d_rdata, 32'hDEADBEEF);
         end else if (n1 < 4 && bus.if_ready) begin
            seq1 = {seq1[2:0], 1'b0}; n1++;
            checkOutput("arb_if_rdata", bus.if_rdata, 32'h80FF0102);
         end
         if (n0 < 4 && bus0.d_ready) begin
            seq0 = {seq0[2:0], 1'b1}; n0++;
         end else if (n0 < 4 && bus0.if_ready) begin
            seq0 = {seq0[2:0], 1'b0}; n0++;
         end
      end
      checkOutput("arb_fair_count", n1, 4);
      checkOutput("arb_fair_order", {28'h0, seq1}, 32'hA);
      checkOutput("arb_strict_count", n0, 4);
      checkOutput("arb_strict_order", {28'h0, seq0}, 32'hF);
      bus.if_req = 1'b0; bus.d_req = 1'b0; bus0.if_req = 1'b0; bus0.d_req = 1'b0;
      repeat (6) tick();

      // Ready stretched by three disabled cycles while in RESP.
      bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_size = 2'b10; bus.d_addr = 32'h100;
      tick();
      tick();
      hi = bus.d_ready ? 1 : 0;
      clk_en = 1'b0;
      bus.d_req = 1'b0;
      repeat (3) begin tick(); hi += bus.d_ready ? 1 : 0; end
      checkOutput("stall_rdata", bus.d_rdata, 32'hDEADBEEF);
      clk_en = 1'b1;
      repeat (4) begin tick(); hi += bus.d_ready ? 1 : 0; end
      checkOutput("stall_ready_cycles", hi, 4);

      // Write strobe gated while stalled in WRITE.
      bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_size = 2'b10; bus.d_addr = 32'h404;
      bus.d_wdata = 32'h12345678;
      tick();
      checkOutput("stall_wr_en_on", {31'h0, bus.ram_wr_en}, 32'h1);
      clk_en = 1'b0;
      #1;
      checkOutput("stall_wr_en_gated", {31'h0, bus.ram_wr_en}, 32'h0);
      repeat (2) tick();
      checkOutput("stall_ram_held", mem[10'h101], 32'h0);
      clk_en = 1'b1;
      tick();
      checkOutput("stall_ram_written", mem[10'h101], 32'h12345678);
      checkOutput("stall_sw_ready", {31'h0, bus.d_ready}, 32'h1);
      bus.d_req = 1'b0;
      repeat (2) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
- Single-port memory bus controller upstream of the unified instruction/data RAM.
- Arbitrates between the CPU instruction-fetch port and the data load/store port, and drives one RAM access at a time.
- Implements byte and halfword stores as read-modify-write, and sign/zero-extends sub-word loads.
- Flags misaligned data accesses without touching memory.

Parameters:
FAIR_ARB, 1, 1 = data wins a tie unless data also won the previous grant (alternating); 0 = strict data priority

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clk_en  input  1  global advance enable; all state and registers hold when 0
if_req  input  1  fetch request; held until if_ready, dropped the cycle after
if_addr  input  32  fetch byte address; bits [1:0] ignored
if_ready  output  1  one-cycle fetch completion pulse
if_rdata  output  32  fetched word, valid while if_ready=1
d_req  input  1  data request; same hold rule as if_req
d_we  input  1  1 = store, 0 = load
d_size  input  2  00 byte, 01 half, 10 word, 11 illegal
d_unsigned  input  1  load zero-extends when 1, sign-extends when 0
d_addr  input  32  data byte address
d_wdata  input  32  store data, right-aligned (bits [7:0] for byte, [15:0] for half)
d_ready  output  1  one-cycle data completion pulse
d_rdata  output  32  extended load result, valid while d_ready=1
d_misalign  output  1  qualifies d_ready: access rejected, no memory effect
ram_addr  output  32  word-aligned RAM address, {addr[31:2],2'b00}
ram_wr_en  output  1  RAM write strobe
ram_wdata  output  32  RAM write word
ram_rdata  input  32  RAM read data, combinational from ram_addr

Behaviour:
- Registers: FSM states IDLE, READ, RMW_RD, WRITE, RESP. Latched request holds addr, size, unsigned, wdata, source, and a merge word. last_grant bit: 1 = data.
- Reset: state IDLE; if_ready=0, d_ready=0, d_misalign=0, if_rdata=0, d_rdata=0, ram_addr=0, ram_wr_en=0, ram_wdata=0, last_grant=0.
- Reset mid-operation aborts the access. No RAM write occurs and no ready pulse is issued.
- clk_en=0: no transitions and no register updates. ram_wr_en is forced 0. Outputs hold their values, so a ready pulse stretches until clk_en=1.
- IDLE accepts requests only in this state.
  - Grant with both requests pending: data wins, except when FAIR_ARB=1 and last_grant=1, in which case fetch wins. Update last_grant on every grant.
  - Misaligned data access: size 01 with addr[0]=1, size 10 with addr[1:0]!=0, or size 11. Go to RESP with d_misalign=1 and d_rdata=0.
  - Load or fetch: go to READ.
  - Word store: go to WRITE with merge word = d_wdata.
  - Byte or half store: go to RMW_RD.
- READ: drive ram_addr; capture ram_rdata into the result; go to RESP.
  - Loads select the byte lane by addr[1:0] and the half lane by addr[1] (little-endian), then extend per d_unsigned.
- RMW_RD: drive ram_addr; merge wdata into the captured word on the selected lane(s); go to WRITE.
- WRITE: drive ram_addr, ram_wdata = merge word, ram_wr_en=1 for exactly one enabled cycle; go to RESP.
- RESP: assert the ready for the granted source for one cycle, with d_misalign as decided; go to IDLE.
  - A request still high in RESP is not re-accepted until IDLE.
- Latency in enabled cycles from the accept edge to the ready cycle: misaligned 1; load, fetch, word store 2; sub-word store 3.
- ram_addr holds its last value outside READ, RMW_RD and WRITE.

Test Plan:
- Word load: RAM[0x100]=0xDEADBEEF, lw 0x100 -> d_ready 2 cycles after accept, d_rdata=0xDEADBEEF, ram_wr_en never high.
- Sub-word loads: RAM[0x200]=0x80FF0102.
  - lb 0x203 -> 0xFFFFFF80; lbu 0x203 -> 0x00000080.
  - lh 0x202 -> 0xFFFF80FF; lhu 0x200 -> 0x00000102.
- Byte store: RAM[0x300]=0x11223344, sb 0x000000AB at 0x301 -> one ram_wr_en pulse with 0x1122AB44, d_ready 3 cycles after accept.
- Misaligned: lw 0x102 and sh 0x105 -> d_ready with d_misalign=1 one cycle after accept, RAM unchanged, d_rdata=0.
- Arbitration: if_req and d_req held continuously, FAIR_ARB=1 -> grants data, fetch, data, fetch. FAIR_ARB=0 -> data every time.
- Disruption: rst_n low during RMW_RD of sb -> RAM unchanged, all outputs 0, no ready. clk_en low in RESP for 3 cycles -> d_ready high for 4 cycles, single completion.
